// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: receives a framed program image (length, payload, XOR checksum)
// and writes little-endian 32-bit words into instruction memory, holding the core until verified.
module imem_boot_loader #(
    parameter int DEPTH   = 80,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam int              TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
    localparam logic [15:0]     DEPTH16 = 16'(DEPTH);

    state_t           state, nxt;
    logic [7:0]       len_lo;
    logic [CNT_W-1:0] len;
    logic [1:0]       bidx;
    logic [23:0]      asm_q;
    logic [7:0]       chk;
    logic [TO_W-1:0]  tmo;

    logic        acc, recv, idle_like, tmo_hit, last_word;
    logic [15:0] nlen;

    assign acc       = rx_valid & rx_ready;
    assign recv      = state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK};
    assign idle_like = state inside {S_IDLE, S_DONE, S_ERROR};
    assign nlen      = {rx_data, len_lo};
    assign last_word = (words_loaded == len - CNT_W'(1));
    // Idle cycles are counted only while a byte is expected; any accepted byte restarts the count.
    assign tmo_hit   = (TIMEOUT > 0) && recv && !acc && (tmo + TO_W'(1) == TO_MAX);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) nxt = S_LEN_LO;
            S_LEN_LO: if (acc) nxt = S_LEN_HI;
            S_LEN_HI: if (acc) nxt = (nlen == 16'd0 || nlen > DEPTH16) ? S_ERROR : S_DATA;
            S_DATA:   if (acc && bidx == 2'd3 && last_word) nxt = S_CHECK;
            S_CHECK:  if (acc) nxt = (rx_data == chk) ? S_DONE : S_ERROR;
            default:  nxt = S_IDLE;
        endcase
        if (tmo_hit) nxt = S_ERROR;
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            len_lo       <= '0;
            len          <= '0;
            bidx         <= '0;
            asm_q        <= '0;
            chk          <= '0;
            tmo          <= '0;
        end else begin
            rx_ready <= nxt inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK};
            done     <= (nxt == S_DONE);
            error    <= (nxt == S_ERROR);
            cpu_hold <= (nxt != S_DONE);
            imem_we  <= 1'b0;

            if (acc)       tmo <= '0;
            else if (recv) tmo <= tmo + TO_W'(1);

            if (start && idle_like) begin
                words_loaded <= '0;
                chk          <= '0;
                bidx         <= '0;
                tmo          <= '0;
            end

            if (acc) begin
                case (state)
                    S_LEN_LO: len_lo <= rx_data;
                    S_LEN_HI: begin
                        len  <= CNT_W'(nlen);
                        bidx <= '0;
                    end
                    S_DATA: begin
                        chk   <= chk ^ rx_data;
                        bidx  <= bidx + 2'd1;
                        asm_q <= {rx_data, asm_q[23:8]};
                        // Write issues in the cycle after the 4th byte while reception continues.
                        if (bidx == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_addr    <= 32'({words_loaded, 2'b00});
                            imem_wdata   <= {rx_data, asm_q};
                            words_loaded <= words_loaded + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected writes are queued from the frame bytes
// and popped by a monitor whenever the loader strobes imem_we.
module tb_imem_boot_loader;

    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic [7:0]  rx_data = 0;
    logic        rx_valid = 0;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    imem_boot_loader #(.DEPTH(80), .CNT_W(16), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_write: addr %h data %h with no write expected", imem_addr, imem_wdata);
            end
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", imem_addr, e.a);
                chk("write_data", imem_wdata, e.d);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit s);
        int n;
        n = 0;
        rx_data = b; rx_valid = 1; start = s;
        while (rx_ready !== 1'b1 && n < 50) begin step(); n++; end
        if (n >= 50) begin
            checks++; errors++;
            $error("FAIL rx_ready_wait: got rx_ready=%b expected 1 within 50 cycles", rx_ready);
        end
        step();
        rx_valid = 0; start = 0;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input int maxgap, input bit inj);
        int n, g;
        wr_t e;
        if (f.size() >= 2) begin
            n = {f[1], f[0]};
            if (n >= 1 && n <= 80)
                for (int w = 0; w < n; w++)
                    if (2 + 4*w + 3 < f.size()) begin
                        e.a = 32'(w * 4);
                        e.d = {f[2+4*w+3], f[2+4*w+2], f[2+4*w+1], f[2+4*w]};
                        exp_q.push_back(e);
                    end
        end
        for (int i = 0; i < f.size(); i++) begin
            g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            if (g > 0) repeat (g) step();
            send_byte(f[i], inj && i >= 2 && i < f.size() - 1 && $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rx_ready"}, rx_ready, 0);
        chk({tag, "_imem_we"}, imem_we, 0);
        chk({tag, "_imem_addr"}, imem_addr, 0);
        chk({tag, "_imem_wdata"}, imem_wdata, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_words_loaded"}, words_loaded, 0);
    endtask

    initial begin
        logic [7:0] good[$];
        logic [7:0] bad[$];
        logic [7:0] fr[$];
        int c0;

        good = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h91};
        bad  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h90};

        repeat (2) step();
        check_reset("reset");
        rst = 0;
        step();

        // 1: valid two-word image, back-to-back bytes
        pulse_start();
        chk("t1_rx_ready_after_start", rx_ready, 1);
        c0 = cyc;
        send_frame(good, 0, 0);
        chk("t1_cycles", cyc - c0, 11);
        chk("t1_done", done, 1);
        chk("t1_error", error, 0);
        chk("t1_cpu_hold", cpu_hold, 0);
        chk("t1_rx_ready", rx_ready, 0);
        chk("t1_words_loaded", words_loaded, 2);
        chk("t1_addr_hold", imem_addr, 32'h4);
        chk("t1_wdata_hold", imem_wdata, 32'h0010_0113);
        chk("t1_queue_empty", exp_q.size(), 0);

        // 2: bad checksum, restart from DONE
        pulse_start();
        chk("t2_done_cleared", done, 0);
        chk("t2_cpu_hold_set", cpu_hold, 1);
        chk("t2_words_cleared", words_loaded, 0);
        send_frame(bad, 0, 0);
        chk("t2_error", error, 1);
        chk("t2_done", done, 0);
        chk("t2_cpu_hold", cpu_hold, 1);
        chk("t2_words_loaded", words_loaded, 2);
        chk("t2_queue_empty", exp_q.size(), 0);

        // 3: oversize length rejected right after LEN_HI
        pulse_start();
        chk("t3_error_cleared", error, 0);
        fr = '{8'h51, 8'h00};
        send_frame(fr, 0, 0);
        chk("t3_error", error, 1);
        chk("t3_rx_ready", rx_ready, 0);
        repeat (4) step();
        chk("t3_words_loaded", words_loaded, 0);
        chk("t3_cpu_hold", cpu_hold, 1);

        // 4: random gaps and ignored start pulses during the payload
        pulse_start();
        send_frame(good, 5, 1);
        chk("t4_done", done, 1);
        chk("t4_error", error, 0);
        chk("t4_cpu_hold", cpu_hold, 0);
        chk("t4_words_loaded", words_loaded, 2);
        chk("t4_queue_empty", exp_q.size(), 0);

        // 5: timeout 16 cycles after the last accepted byte
        pulse_start();
        fr = '{8'h02, 8'h00, 8'h93};
        send_frame(fr, 0, 0);
        repeat (15) step();
        chk("t5_error_before", error, 0);
        chk("t5_rx_ready_before", rx_ready, 1);
        step();
        chk("t5_error_at_16", error, 1);
        chk("t5_rx_ready_at_16", rx_ready, 0);

        // 6: reset mid-load after five payload bytes, then a clean load
        pulse_start();
        fr = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13};
        send_frame(fr, 0, 0);
        chk("t6_words_mid", words_loaded, 1);
        rst = 1;
        step();
        check_reset("t6_reset");
        rst = 0;
        step();
        pulse_start();
        send_frame(good, 0, 0);
        chk("t6_done", done, 1);
        chk("t6_cpu_hold", cpu_hold, 0);
        chk("t6_words_loaded", words_loaded, 2);
        chk("t6_queue_empty", exp_q.size(), 0);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
